regfile_writeback_arbiter: RTL and testbench

Merges the two result producers of the pipeline's final stage into the register file's single write port. Load results (LSU) are written immediately; ALU results pass through a small skid FIFO when they collide with a load. It drives `write_enable`/`write_address`/`write_data` of the register file from registered outputs. It also answers hazard queries about register writes that are still pending.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 94 +++++++++
 rtl/regfile_writeback_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the register-file writeback arbiter.
//   XLEN        : register data width
//   REG_ADDR_W  : register address width
//   wb_req_t    : one pending register write {rd, data}
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of wb_req_t used to park ALU results that lose the
// write port to a load. It also exposes per-entry valid/rd vectors so the
// top level can scan every queued destination for hazard queries.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push_i, pushReq_i : enqueue request and payload (ignored when full)
//   pop_i          : dequeue request (ignored when empty)
//   head_o         : entry at the read pointer
//   count_o        : number of queued entries
//   entryValid_o   : per-slot occupancy
//   entryRd_o      : per-slot destination register
// -----------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push_i,
   input  wb_req_t                              pushReq_i,
   input  logic                                 pop_i,
   output wb_req_t                              head_o,
   output logic [$clog2(DEPTH):0]               count_o,
   output logic [DEPTH-1:0]                     entryValid_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entryRd_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_req_t         mem_q [DEPTH];
   logic [PW-1:0]   rdPtr_q, rdPtr_d;
   logic [PW-1:0]   wrPtr_q, wrPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            doPush;
   logic            doPop;

   // Guard the raw requests against overflow/underflow so the pointers can
   // never run past each other, whatever the caller does.
   always_comb begin
      doPush  = push_i && (count_q != CW'(DEPTH));
      doPop   = pop_i && (count_q != '0);
      rdPtr_d = doPop  ? rdPtr_q + PW'(1) : rdPtr_q;
      wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + CW'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and count state; reset empties the queue instantly, so any
   // parked writes are simply forgotten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushReq_i;
      end
   end

   // A slot is occupied when its distance from the read pointer (modulo the
   // depth) is below the count; the power-of-2 depth makes the wrap free.
   always_comb begin
      logic [PW-1:0] offset;
      offset       = '0;
      entryValid_o = '0;
      entryRd_o    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset          = PW'(i) - rdPtr_q;
         entryValid_o[i] = ({1'b0, offset} < count_q);
         entryRd_o[i]    = mem_q[i].rd;
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
// Merges load (LSU) and ALU results onto the register file's single write
// port. Loads always win; ALU results that lose are parked in a skid FIFO
// and drained in order. The write port outputs are registered. Hazard
// queries report whether a write to a register is still pending.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   alu_valid/alu_ready          : ALU result handshake
//   alu_rd, alu_data             : ALU destination and result
//   lsu_valid, lsu_rd, lsu_data  : load result (always accepted)
//   rf_we, rf_waddr, rf_wdata    : registered register-file write port
//   query_addr1/2, query_busy1/2 : combinational pending-write queries
//   fifo_count                   : number of queued ALU results
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [REG_ADDR_W-1:0]   alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    lsu_valid,
   input  logic [REG_ADDR_W-1:0]   lsu_rd,
   input  logic [XLEN-1:0]         lsu_data,
   output logic                    rf_we,
   output logic [REG_ADDR_W-1:0]   rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   input  logic [REG_ADDR_W-1:0]   query_addr1,
   input  logic [REG_ADDR_W-1:0]   query_addr2,
   output logic                    query_busy1,
   output logic                    query_busy2,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_req_t                             fifoHead;
   wb_req_t                             aluReq;
   logic [CW-1:0]                       fifoCount;
   logic [DEPTH-1:0]                    entryValid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]    entryRd;

   logic                    fifoEmpty;
   logic                    fifoFull;
   logic                    aluFire;
   logic                    lsuSel;
   logic                    popSel;
   logic                    bypassSel;
   logic                    pushEn;

   logic                    rfWe_q, rfWe_d;
   logic [REG_ADDR_W-1:0]   rfWaddr_q, rfWaddr_d;
   logic [XLEN-1:0]         rfWdata_q, rfWdata_d;

   assign aluReq = '{rd: alu_rd, data: alu_data};

   wb_fifo #(
      .DEPTH        (DEPTH)
   ) uFifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (pushEn),
      .pushReq_i    (aluReq),
      .pop_i        (popSel),
      .head_o       (fifoHead),
      .count_o      (fifoCount),
      .entryValid_o (entryValid),
      .entryRd_o    (entryRd)
   );

   // Selection: a load with a real destination wins, then the FIFO head,
   // then a direct bypass of the ALU input. The bypass only happens on an
   // empty FIFO so ALU results stay in acceptance order. ALU results to x0
   // are accepted but never queued or written, and an x0 load does not
   // count as a winner, so the FIFO still drains that cycle. Ready is taken
   // from the registered count only, so a full FIFO refuses new results even
   // in a cycle where it pops.
   always_comb begin
      fifoEmpty = (fifoCount == '0);
      fifoFull  = (fifoCount == CW'(DEPTH));
      alu_ready = !fifoFull && !rst;
      aluFire   = alu_valid && alu_ready;
      lsuSel    = lsu_valid && (lsu_rd != '0);
      popSel    = !lsuSel && !fifoEmpty;
      bypassSel = !lsuSel && fifoEmpty && aluFire && (alu_rd != '0);
      pushEn    = aluFire && (alu_rd != '0) && (lsuSel || !fifoEmpty);

      rfWe_d    = 1'b0;
      rfWaddr_d = rfWaddr_q;
      rfWdata_d = rfWdata_q;
      if (lsuSel) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = lsu_rd;
         rfWdata_d = lsu_data;
      end else if (popSel) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = fifoHead.rd;
         rfWdata_d = fifoHead.data;
      end else if (bypassSel) begin
         rfWe_d    = 1'b1;
         rfWaddr_d = alu_rd;
         rfWdata_d = alu_data;
      end
   end

   // Output register: the enable pulses for one cycle per write while the
   // address and data keep their last value between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rfWe_q    <= 1'b0;
         rfWaddr_q <= '0;
         rfWdata_q <= '0;
      end else begin
         rfWe_q    <= rfWe_d;
         rfWaddr_q <= rfWaddr_d;
         rfWdata_q <= rfWdata_d;
      end
   end

   // Hazard query: a register is busy while it sits in any occupied FIFO
   // slot or is being presented on the write port right now. x0 is never
   // busy because it is never written.
   always_comb begin
      query_busy1 = 1'b0;
      query_busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryValid[i] && (entryRd[i] == query_addr1)) begin
            query_busy1 = 1'b1;
         end
         if (entryValid[i] && (entryRd[i] == query_addr2)) begin
            query_busy2 = 1'b1;
         end
      end
      if (rfWe_q && (rfWaddr_q == query_addr1)) begin
         query_busy1 = 1'b1;
      end
      if (rfWe_q && (rfWaddr_q == query_addr2)) begin
         query_busy2 = 1'b1;
      end
      if (query_addr1 == '0) begin
         query_busy1 = 1'b0;
      end
      if (query_addr2 == '0) begin
         query_busy2 = 1'b0;
      end
   end

   assign rf_we      = rfWe_q;
   assign rf_waddr   = rfWaddr_q;
   assign rf_wdata   = rfWdata_q;
   assign fifo_count = fifoCount;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
// Directed bench for the writeback arbiter with DEPTH=2. Inputs change 1 ns
// after each rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  query_addr1;
   logic [4:0]  query_addr2;
   logic        query_busy1;
   logic        query_busy2;
   logic [1:0]  fifo_count;

   int total;
   int bad;

   regfile_writeback_arbiter #(
      .DEPTH       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .query_addr1 (query_addr1),
      .query_addr2 (query_addr2),
      .query_busy1 (query_busy1),
      .query_busy2 (query_busy2),
      .fifo_count  (fifo_count)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 ns past the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      lsu_valid = 1'b0;
      lsu_rd    = '0;
      lsu_data  = '0;
   endtask

   task automatic test_reset();
      idleInputs();
      query_addr1 = 5'd7;
      query_addr2 = 5'd0;
      rst = 1'b1;
      step();
      step();
      total++; if (rf_we !== 1'b0) begin $display("[TB] FAIL reset_we got=%0b want=0", rf_we); bad++; end
      total++; if (rf_waddr !== 5'd0) begin $display("[TB] FAIL reset_waddr got=%0d want=0", rf_waddr); bad++; end
      total++; if (rf_wdata !== 32'd0) begin $display("[TB] FAIL reset_wdata got=%h want=0", rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd0) begin $display("[TB] FAIL reset_count got=%0d want=0", fifo_count); bad++; end
      total++; if (alu_ready !== 1'b0) begin $display("[TB] FAIL reset_ready got=%0b want=0", alu_ready); bad++; end
      total++; if (query_busy1 !== 1'b0) begin $display("[TB] FAIL reset_busy1 got=%0b want=0", query_busy1); bad++; end
      rst = 1'b0;
      #1;
      total++; if (alu_ready !== 1'b1) begin $display("[TB] FAIL post_reset_ready got=%0b want=1", alu_ready); bad++; end
      step();
   endtask

   task automatic test_bypass();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5A5A5;
      step();
      idleInputs();
      total++; if (rf_we !== 1'b1) begin $display("[TB] FAIL bypass_we got=%0b want=1", rf_we); bad++; end
      total++; if (rf_waddr !== 5'd5) begin $display("[TB] FAIL bypass_waddr got=%0d want=5", rf_waddr); bad++; end
      total++; if (rf_wdata !== 32'hA5A5A5A5) begin $display("[TB] FAIL bypass_wdata got=%h want=a5a5a5a5", rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd0) begin $display("[TB] FAIL bypass_count got=%0d want=0", fifo_count); bad++; end
      step();
      total++; if (rf_we !== 1'b0) begin $display("[TB] FAIL bypass_pulse got=%0b want=0", rf_we); bad++; end
      total++; if (rf_waddr !== 5'd5) begin $display("[TB] FAIL bypass_hold got=%0d want=5", rf_waddr); bad++; end
   endtask

   task automatic test_collision();
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      step();
      idleInputs();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
         $display("[TB] FAIL coll_lsu got=%0b/%0d/%h want=1/3/11", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd1) begin $display("[TB] FAIL coll_count1 got=%0d want=1", fifo_count); bad++; end
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
         $display("[TB] FAIL coll_alu got=%0b/%0d/%h want=1/4/22", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd0) begin $display("[TB] FAIL coll_count0 got=%0d want=0", fifo_count); bad++; end
      step();
      total++; if (rf_we !== 1'b0) begin $display("[TB] FAIL coll_idle got=%0b want=0", rf_we); bad++; end
   endtask

   task automatic test_backpressure();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9;
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
         $display("[TB] FAIL bp_lsu got=%0b/%0d want=1/9", rf_we, rf_waddr); bad++; end
      total++; if (fifo_count !== 2'd1 || alu_ready !== 1'b1) begin
         $display("[TB] FAIL bp_first got=%0d/%0b want=1/1", fifo_count, alu_ready); bad++; end
      alu_rd = 5'd11; alu_data = 32'h101;
      step();
      total++; if (fifo_count !== 2'd2 || alu_ready !== 1'b0) begin
         $display("[TB] FAIL bp_full got=%0d/%0b want=2/0", fifo_count, alu_ready); bad++; end
      alu_rd = 5'd12; alu_data = 32'h102;
      step();
      total++; if (fifo_count !== 2'd2 || alu_ready !== 1'b0) begin
         $display("[TB] FAIL bp_stall got=%0d/%0b want=2/0", fifo_count, alu_ready); bad++; end
      lsu_valid = 1'b0; lsu_rd = '0;
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h100) begin
         $display("[TB] FAIL bp_drain1 got=%0b/%0d/%h want=1/10/100", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd1 || alu_ready !== 1'b1) begin
         $display("[TB] FAIL bp_reopen got=%0d/%0b want=1/1", fifo_count, alu_ready); bad++; end
      step();
      alu_valid = 1'b0;
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h101) begin
         $display("[TB] FAIL bp_drain2 got=%0b/%0d/%h want=1/11/101", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd1) begin $display("[TB] FAIL bp_pushpop got=%0d want=1", fifo_count); bad++; end
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h102) begin
         $display("[TB] FAIL bp_third got=%0b/%0d/%h want=1/12/102", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd0) begin $display("[TB] FAIL bp_empty got=%0d want=0", fifo_count); bad++; end
      idleInputs();
      step();
   endtask

   task automatic test_x0();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBEEF;
      total++; if (alu_ready !== 1'b1) begin $display("[TB] FAIL x0_ready got=%0b want=1", alu_ready); bad++; end
      step();
      idleInputs();
      total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
         $display("[TB] FAIL x0_write got=%0b/%0d want=0/0", rf_we, fifo_count); bad++; end
      step();
      total++; if (rf_we !== 1'b0) begin $display("[TB] FAIL x0_late got=%0b want=0", rf_we); bad++; end
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
      step();
      alu_valid = 1'b0;
      lsu_rd = 5'd0; lsu_data = 32'hFFFF;
      total++; if (fifo_count !== 2'd1 || rf_waddr !== 5'd3) begin
         $display("[TB] FAIL x0_setup got=%0d/%0d want=1/3", fifo_count, rf_waddr); bad++; end
      step();
      idleInputs();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
         $display("[TB] FAIL x0_drain got=%0b/%0d/%h want=1/6/66", rf_we, rf_waddr, rf_wdata); bad++; end
      total++; if (fifo_count !== 2'd0) begin $display("[TB] FAIL x0_count got=%0d want=0", fifo_count); bad++; end
      step();
   endtask

   task automatic test_hazard();
      query_addr1 = 5'd7;
      query_addr2 = 5'd0;
      #1;
      total++; if (query_busy1 !== 1'b0) begin $display("[TB] FAIL hz_idle got=%0b want=0", query_busy1); bad++; end
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      step();
      idleInputs();
      total++; if (query_busy1 !== 1'b1) begin $display("[TB] FAIL hz_queued got=%0b want=1", query_busy1); bad++; end
      total++; if (query_busy2 !== 1'b0) begin $display("[TB] FAIL hz_x0 got=%0b want=0", query_busy2); bad++; end
      query_addr2 = 5'd2;
      #1;
      total++; if (query_busy2 !== 1'b1) begin $display("[TB] FAIL hz_port got=%0b want=1", query_busy2); bad++; end
      step();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || query_busy1 !== 1'b1) begin
         $display("[TB] FAIL hz_write got=%0b/%0d/%0b want=1/7/1", rf_we, rf_waddr, query_busy1); bad++; end
      total++; if (query_busy2 !== 1'b0) begin $display("[TB] FAIL hz_done2 got=%0b want=0", query_busy2); bad++; end
      step();
      total++; if (query_busy1 !== 1'b0) begin $display("[TB] FAIL hz_clear got=%0b want=0", query_busy1); bad++; end
   endtask

   task automatic test_reset_mid();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
      alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
      step();
      alu_rd = 5'd14; alu_data = 32'h14;
      step();
      idleInputs();
      total++; if (fifo_count !== 2'd2) begin $display("[TB] FAIL rm_filled got=%0d want=2", fifo_count); bad++; end
      #2;
      rst = 1'b1;
      #1;
      total++; if (fifo_count !== 2'd0 || rf_we !== 1'b0 || alu_ready !== 1'b0) begin
         $display("[TB] FAIL rm_async got=%0d/%0b/%0b want=0/0/0", fifo_count, rf_we, alu_ready); bad++; end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
            $display("[TB] FAIL rm_after%0d got=%0b/%0d want=0/0", i, rf_we, fifo_count); bad++; end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idleInputs();
      query_addr1 = '0;
      query_addr2 = '0;
      test_reset();
      test_bypass();
      test_collision();
      test_backpressure();
      test_x0();
      test_hazard();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends even if the clock or a task stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule
